instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the core's immediate decode path. Accepts decoded instruction fields plus a full 32-bit immediate over a valid/ready request channel.
- Range-checks the immediate for the target format and packs a legal RV32I (plus PIM) instruction word.
- Streams packed words into instruction memory through a registered write port with backpressure and an auto-incrementing address.
- Used by the debug/boot loader to inject programs; also used as a golden encoder in the core testbenches.

Parameters:
- ADDR_W, 32, width of the IMEM byte address.
- BASE_ADDR, 32'h0000_0000, first write address after start_i.
- DEPTH, 1024, number of 32-bit words in the writable window.
- WRAP, 1'b0, 1 = address wraps to BASE_ADDR after the last word; 0 = stop and assert done_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse: reset the address to BASE_ADDR, clear counters, enter RUN.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid & ready.
- opcode_i  in  7  major opcode (codebase opcode constants, incl. OPCODE_PIM).
- rd_i  in  5  destination register.
- funct3_i  in  3  funct3.
- rs1_i  in  5  source 1.
- rs2_i  in  5  source 2.
- funct7_i  in  7  funct7; R-type, and shifts (bit5 selects SRAI).
- imm_i  in  32  full signed/unsigned immediate to encode.
- imem_we_o  out  1  write strobe (valid).
- imem_ready_i  in  1  memory accepts the write this cycle.
- imem_addr_o  out  ADDR_W  word-aligned byte address.
- imem_wdata_o  out  32  encoded instruction.
- err_o  out  1  one-cycle pulse: request rejected for a bad immediate or unknown opcode.
- err_cnt_o  out  8  saturating reject count.
- wr_cnt_o  out  16  words written since start_i (wraps).
- done_o  out  1  window full (WRAP=0 only); level.

Behaviour:
Reset and FSM:
- Reset: state IDLE; all outputs 0; imem_addr_o = BASE_ADDR.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i.
  - RUN -> DONE when the write to the last window address completes and WRAP=0.
  - DONE -> RUN on start_i.
  - start_i in any state: address = BASE_ADDR, counters = 0, any pending output word discarded.
  - rst_i or start_i mid-transfer aborts with no partial write.
- req_ready_o = (state==RUN) & (!out_valid | imem_ready_i). This gives a one-entry output register with same-cycle refill.

Encoding (combinational, from accepted request to output register; latency 1 cycle from accept to imem_we_o):
- I/LOAD/JALR: imm[11:0] in [31:20].
  - I with funct3 001/101: {funct7_i, imm[4:0]}. Reject if imm[31:5] != 0.
- STORE, PIM: S-type, {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
- BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}. Reject if imm[0]=1.
- JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}. Reject if imm[0]=1.
- LUI/AUIPC: {imm[31:12], rd, op}. Reject if imm[11:0] != 0.
- R-type: {funct7, rs2, rs1, f3, rd, op}; imm ignored.
- Signed range checks:
  - I/S/PIM: imm must equal sext(imm[11:0]).
  - B: sext(imm[12:0]).
  - J: sext(imm[20:0]).
- Unknown opcode: reject.

Reject handling:
- Request is consumed (handshake completes) and no write occurs.
- err_o pulses the cycle after the accept.
- err_cnt_o increments and saturates at 255.

Output channel:
- imem_we_o/addr/wdata stay stable while imem_we_o & !imem_ready_i.
- On a completed write: addr += 4, wr_cnt_o += 1.
- After BASE_ADDR + 4*(DEPTH-1):
  - WRAP=1: next address = BASE_ADDR.
  - WRAP=0: go to DONE; req_ready_o = 0.
- Simultaneous output drain and new accept: both happen; no bubble.

Decomposition:
- Shared package instr_enc_pkg:
  - enum fmt_e {FMT_R, FMT_I, FMT_SHAMT, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}.
  - FUNCT3_SL / FUNCT3_SR constants.
  - Opcode constants from the existing opcode include.
- Sub-module instr_field_packer: purely combinational; opcode/fields/imm -> {fmt, word, range_ok}. The top level holds the FSM, output register and counters.

Test Plan:
- ADDI x1,x0,-1 (op 0010011, rd 1, f3 0, imm 32'hFFFF_FFFF) after start_i -> imem_wdata_o=32'h FFF0_0093 at addr BASE_ADDR, one cycle after accept.
- SW x2,8(x1) then LUI x5,0x12345000 back-to-back, imem_ready_i=1 -> 32'h0020_A423 @ +0, then 32'h1234_52B7 @ +4, on consecutive cycles.
- JAL x1,+2048 with imem_ready_i held low for 3 cycles -> 32'h0010_00EF held stable for 4 cycles; req_ready_o=0 during the stall.
- BEQ imm=3; ADDI imm=2048; SLLI imm=32 -> three err_o pulses, err_cnt_o=3, no imem_we_o, address unchanged.
- DEPTH=4, WRAP=0, 5 valid requests -> 4 writes, done_o=1, 5th request never accepted. With WRAP=1, the 5th request is written to BASE_ADDR.
- start_i asserted while an output word is stalled -> word dropped, imem_we_o=0 the next cycle, addr=BASE_ADDR, wr_cnt_o=0.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared encoding constants, instruction formats and range-check helper
// for the instruction encoder.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SHAMT, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    localparam logic [2:0] FUNCT3_SL = 3'b001;
    localparam logic [2:0] FUNCT3_SR = 3'b101;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_PIM    = 7'b0001011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    // True when v equals the sign extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (bits - 1);
        return ((v & mask) == '0) || ((v & mask) == mask);
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: decoded fields plus a 32-bit immediate to an
// RV32I/PIM instruction word, with the format's immediate range check.
module instr_field_packer
    import instr_enc_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output fmt_e        o_fmt,
    output logic [31:0] o_word,
    output logic        o_range_ok
);

    always_comb begin
        o_fmt = FMT_BAD;
        case (i_opcode)
            OPCODE_LOAD, OPCODE_JALR: o_fmt = FMT_I;
            OPCODE_OP_IMM:            o_fmt = (i_funct3 == FUNCT3_SL || i_funct3 == FUNCT3_SR)
                                              ? FMT_SHAMT : FMT_I;
            OPCODE_STORE, OPCODE_PIM: o_fmt = FMT_S;
            OPCODE_BRANCH:            o_fmt = FMT_B;
            OPCODE_JAL:               o_fmt = FMT_J;
            OPCODE_LUI, OPCODE_AUIPC: o_fmt = FMT_U;
            OPCODE_OP:                o_fmt = FMT_R;
            default:                  o_fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        o_word     = '0;
        o_range_ok = 1'b0;
        case (o_fmt)
            FMT_R: begin
                o_word     = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_range_ok = 1'b1;
            end
            FMT_I: begin
                o_word     = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_range_ok = fits_signed(i_imm, 12);
            end
            FMT_SHAMT: begin
                o_word     = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_range_ok = (i_imm[31:5] == '0);
            end
            FMT_S: begin
                o_word     = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_range_ok = fits_signed(i_imm, 12);
            end
            FMT_B: begin
                o_word     = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                              i_imm[4:1], i_imm[11], i_opcode};
                o_range_ok = fits_signed(i_imm, 13) && !i_imm[0];
            end
            FMT_J: begin
                o_word     = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_range_ok = fits_signed(i_imm, 21) && !i_imm[0];
            end
            FMT_U: begin
                o_word     = {i_imm[31:12], i_rd, i_opcode};
                o_range_ok = (i_imm[11:0] == '0);
            end
            default: begin
                o_word     = '0;
                o_range_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded requests, packs them and streams the
// words into IMEM through a one-entry output register with auto-increment.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = 32'h0000_0000,
    parameter int unsigned         DEPTH     = 1024,
    parameter bit                  WRAP      = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              imem_we_o,
    input  logic              imem_ready_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o,
    output logic [15:0]       wr_cnt_o,
    output logic              done_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(4 * (DEPTH - 1));

    state_e              r_state;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [7:0]          r_err_cnt;
    logic [15:0]         r_wr_cnt;

    fmt_e                w_fmt;
    logic [31:0]         w_word;
    logic                w_range_ok;
    logic                w_last;
    logic                w_drain;
    logic                w_ready;
    logic                w_accept;
    logic                w_good;

    instr_field_packer u_packer (
        .i_opcode   (opcode_i),
        .i_rd       (rd_i),
        .i_funct3   (funct3_i),
        .i_rs1      (rs1_i),
        .i_rs2      (rs2_i),
        .i_funct7   (funct7_i),
        .i_imm      (imm_i),
        .o_fmt      (w_fmt),
        .o_word     (w_word),
        .o_range_ok (w_range_ok)
    );

    assign w_last  = (r_addr == LAST_ADDR);
    assign w_drain = r_out_valid & imem_ready_i;
    // Refill-on-drain is suppressed while the last window word is pending
    // (WRAP=0), and during start_i so a request is never consumed then dropped.
    assign w_ready  = (r_state == ST_RUN) & !start_i &
                      (!r_out_valid | (imem_ready_i & !(w_last & !WRAP)));
    assign w_accept = req_valid_i & w_ready;
    assign w_good   = w_accept & w_range_ok & (w_fmt != FMT_BAD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_wr_cnt    <= '0;
        end else if (start_i) begin
            r_state     <= ST_RUN;
            r_out_valid <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_wr_cnt    <= '0;
        end else begin
            r_err <= w_accept & !w_good;
            if (w_accept && !w_good && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;

            if (w_drain) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
                if (w_last && WRAP) begin
                    r_addr <= BASE_ADDR;
                end else begin
                    r_addr <= r_addr + ADDR_W'(4);
                    if (w_last) r_state <= ST_DONE;
                end
            end

            if (w_good) begin
                r_out_valid <= 1'b1;
                r_wdata     <= w_word;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign req_ready_o  = w_ready;
    assign imem_we_o    = r_out_valid;
    assign imem_addr_o  = r_addr;
    assign imem_wdata_o = r_wdata;
    assign err_o        = r_err;
    assign err_cnt_o    = r_err_cnt;
    assign wr_cnt_o     = r_wr_cnt;
    assign done_o       = (r_state == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: a WRAP=0 instance carries most tests,
// a WRAP=1 instance covers address wrap-around.
module tb_instr_encoder;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_STR = 7'b0100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_R   = 7'b0110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b0, start2 = 1'b0, req_valid = 1'b0, imem_ready = 1'b0;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] imm = '0;

    logic        req_ready, we, err, done;
    logic [31:0] addr, wdata;
    logic [7:0]  err_cnt;
    logic [15:0] wr_cnt;
    logic        req_ready2, we2, err2, done2;
    logic [31:0] addr2, wdata2;
    logic [7:0]  err_cnt2;
    logic [15:0] wr_cnt2;

    int n_pass = 0;
    int n_checks = 0;
    bit use2 = 1'b0;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0100), .DEPTH(4), .WRAP(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .opcode_i(opcode), .rd_i(rd), .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2),
        .funct7_i(funct7), .imm_i(imm), .imem_we_o(we), .imem_ready_i(imem_ready),
        .imem_addr_o(addr), .imem_wdata_o(wdata), .err_o(err), .err_cnt_o(err_cnt),
        .wr_cnt_o(wr_cnt), .done_o(done)
    );

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0200), .DEPTH(4), .WRAP(1'b1)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .req_valid_i(req_valid), .req_ready_o(req_ready2),
        .opcode_i(opcode), .rd_i(rd), .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2),
        .funct7_i(funct7), .imm_i(imm), .imem_we_o(we2), .imem_ready_i(imem_ready),
        .imem_addr_o(addr2), .imem_wdata_o(wdata2), .err_o(err2), .err_cnt_o(err_cnt2),
        .wr_cnt_o(wr_cnt2), .done_o(done2)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input bit second);
        if (second) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic set_req(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                           input logic [31:0] im);
        opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
    endtask

    // Holds valid until the selected DUT accepts; returns at posedge+1 after the accept.
    task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                        input logic [31:0] im);
        bit ok, rdy;
        ok = 1'b0;
        set_req(op, d, f3, s1, s2, f7, im);
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = use2 ? req_ready2 : req_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1'b1; break; end
        end
        req_valid = 1'b0;
        if (ok !== 1'b1) $display("FAIL accept: got no handshake want handshake (op %b)", op); else n_pass++;
        n_checks++;
    endtask

    task automatic test_reset();
        set_req(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        if (req_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", req_ready); else n_pass++; n_checks++;
        if (we !== 1'b0) $display("FAIL rst_we: got %b want 0", we); else n_pass++; n_checks++;
        if (addr !== 32'h100) $display("FAIL rst_addr: got %h want 00000100", addr); else n_pass++; n_checks++;
        if (addr2 !== 32'h200) $display("FAIL rst_addr2: got %h want 00000200", addr2); else n_pass++; n_checks++;
        if ({err, done, err_cnt, wr_cnt} !== 26'd0)
            $display("FAIL rst_status: got err=%b done=%b ec=%0d wc=%0d want all 0", err, done, err_cnt, wr_cnt);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1 req_valid = 1'b0;
    endtask

    task automatic test_addi();
        pulse_start(1'b0);
        imem_ready = 1'b1;
        send(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        if (we !== 1'b1) $display("FAIL addi_we: got %b want 1", we); else n_pass++; n_checks++;
        if (wdata !== 32'hFFF0_0093) $display("FAIL addi_wdata: got %h want fff00093", wdata); else n_pass++; n_checks++;
        if (addr !== 32'h100) $display("FAIL addi_addr: got %h want 00000100", addr); else n_pass++; n_checks++;
        @(posedge clk); #1;
        @(negedge clk);
        if (we !== 1'b0) $display("FAIL addi_we_after: got %b want 0", we); else n_pass++; n_checks++;
        if (wr_cnt !== 16'd1) $display("FAIL addi_wrcnt: got %0d want 1", wr_cnt); else n_pass++; n_checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        pulse_start(1'b0);
        imem_ready = 1'b1;
        set_req(OP_STR, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 32'd8);
        req_valid = 1'b1;
        @(negedge clk);
        if (req_ready !== 1'b1) $display("FAIL b2b_ready0: got %b want 1", req_ready); else n_pass++; n_checks++;
        @(posedge clk); #1;
        set_req(OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
        @(negedge clk);
        if ({we, addr, wdata} !== {1'b1, 32'h100, 32'h0020_A423})
            $display("FAIL b2b_sw: got we=%b addr=%h data=%h want 1/00000100/0020a423", we, addr, wdata);
        else n_pass++;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", req_ready); else n_pass++; n_checks++;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        if ({we, addr, wdata} !== {1'b1, 32'h104, 32'h1234_52B7})
            $display("FAIL b2b_lui: got we=%b addr=%h data=%h want 1/00000104/123452b7", we, addr, wdata);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
        @(negedge clk);
        if ({we, wr_cnt} !== {1'b0, 16'd2}) $display("FAIL b2b_end: got we=%b wc=%0d want 0/2", we, wr_cnt); else n_pass++;
        n_checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        pulse_start(1'b0);
        imem_ready = 1'b0;
        send(OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) imem_ready = 1'b1;
            @(negedge clk);
            if ({we, addr, wdata} !== {1'b1, 32'h100, 32'h0010_00EF})
                $display("FAIL stall_hold%0d: got we=%b addr=%h data=%h want 1/00000100/001000ef", i, we, addr, wdata);
            else n_pass++;
            n_checks++;
            if (i < 3) begin
                if (req_ready !== 1'b0) $display("FAIL stall_ready%0d: got %b want 0", i, req_ready); else n_pass++;
                n_checks++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        if ({we, addr, wr_cnt} !== {1'b0, 32'h104, 16'd1})
            $display("FAIL stall_drain: got we=%b addr=%h wc=%0d want 0/00000104/1", we, addr, wr_cnt);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        pulse_start(1'b0);
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: send(OP_BR,  5'd0, 3'b000, 5'd1, 5'd2, 7'd0, 32'd3);
                1: send(OP_IMM, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd2048);
                default: send(OP_IMM, 5'd1, 3'b001, 5'd1, 5'd0, 7'd0, 32'd32);
            endcase
            @(negedge clk);
            if ({err, we} !== 2'b10) $display("FAIL err_pulse%0d: got err=%b we=%b want 1/0", i, err, we); else n_pass++;
            n_checks++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        if ({err, err_cnt} !== {1'b0, 8'd3}) $display("FAIL err_cnt: got err=%b ec=%0d want 0/3", err, err_cnt); else n_pass++;
        n_checks++;
        if ({addr, wr_cnt} !== {32'h100, 16'd0}) $display("FAIL err_addr: got addr=%h wc=%0d want 00000100/0", addr, wr_cnt); else n_pass++;
        n_checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_formats();
        pulse_start(1'b0);
        imem_ready = 1'b1;
        send(OP_BR, 5'd0, 3'b000, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
        @(negedge clk);
        if ({we, addr, wdata} !== {1'b1, 32'h100, 32'hFE20_8EE3})
            $display("FAIL fmt_beq: got we=%b addr=%h data=%h want 1/00000100/fe208ee3", we, addr, wdata);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
        send(OP_R, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        if ({we, addr, wdata} !== {1'b1, 32'h104, 32'h0020_81B3})
            $display("FAIL fmt_add: got we=%b addr=%h data=%h want 1/00000104/002081b3", we, addr, wdata);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
        send(OP_IMM, 5'd5, 3'b101, 5'd6, 5'd0, 7'h20, 32'd3);
        @(negedge clk);
        if ({we, addr, wdata} !== {1'b1, 32'h108, 32'h4033_5293})
            $display("FAIL fmt_srai: got we=%b addr=%h data=%h want 1/00000108/40335293", we, addr, wdata);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
        send(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
        @(negedge clk);
        if ({err, we, err_cnt} !== {1'b1, 1'b0, 8'd1})
            $display("FAIL fmt_badop: got err=%b we=%b ec=%0d want 1/0/1", err, we, err_cnt);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_done();
        bit leaked;
        pulse_start(1'b0);
        imem_ready = 1'b1;
        for (int k = 0; k < 4; k++) send(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'(k));
        set_req(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4);
        req_valid = 1'b1;
        @(negedge clk);
        if ({we, addr, wdata} !== {1'b1, 32'h10C, 32'h0030_0093})
            $display("FAIL done_last: got we=%b addr=%h data=%h want 1/0000010c/00300093", we, addr, wdata);
        else n_pass++;
        n_checks++;
        leaked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready) leaked = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        if (leaked !== 1'b0) $display("FAIL done_ready: got accepted 5th want never"); else n_pass++; n_checks++;
        if ({done, we, wr_cnt} !== {1'b1, 1'b0, 16'd4})
            $display("FAIL done_state: got done=%b we=%b wc=%0d want 1/0/4", done, we, wr_cnt);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        use2 = 1'b1;
        pulse_start(1'b1);
        imem_ready = 1'b1;
        for (int k = 0; k < 5; k++) send(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'(k));
        @(negedge clk);
        if ({we2, addr2, wdata2, wr_cnt2} !== {1'b1, 32'h200, 32'h0040_0093, 16'd4})
            $display("FAIL wrap_5th: got we=%b addr=%h data=%h wc=%0d want 1/00000200/00400093/4", we2, addr2, wdata2, wr_cnt2);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
        @(negedge clk);
        if ({we2, done2, wr_cnt2} !== {1'b0, 1'b0, 16'd5})
            $display("FAIL wrap_end: got we=%b done=%b wc=%0d want 0/0/5", we2, done2, wr_cnt2);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
        use2 = 1'b0;
    endtask

    task automatic test_start_abort();
        pulse_start(1'b0);
        imem_ready = 1'b1;
        send(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        @(posedge clk); #1 imem_ready = 1'b0;
        send(OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd6);
        @(negedge clk);
        if ({we, addr, wr_cnt} !== {1'b1, 32'h104, 16'd1})
            $display("FAIL abort_pre: got we=%b addr=%h wc=%0d want 1/00000104/1", we, addr, wr_cnt);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
        pulse_start(1'b0);
        @(negedge clk);
        if ({we, addr, wr_cnt} !== {1'b0, 32'h100, 16'd0})
            $display("FAIL abort_post: got we=%b addr=%h wc=%0d want 0/00000100/0", we, addr, wr_cnt);
        else n_pass++;
        n_checks++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_errors();
        test_formats();
        test_done();
        test_wrap();
        test_start_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
